if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the MIPS datapath. Owns the program counter and next-PC selection (PC+4 or redirect).
//  Drives a req/ack instruction-memory port and loads the IF/ID pipeline register that feeds decode.
//  Absorbs decode stalls with a one-entry hold buffer.
//  Resolves branch/jump redirects, including redirects that arrive while a memory access is outstanding.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded at reset
//  NOP_INSTR  32'h0000_0000  value driven on ifid_instr when the IF/ID entry is invalid (sll $0,$0,0)
// PORTS
//  CLK           in   1   clock; all state updates on posedge
//  RESET         in   1   synchronous, active-low reset; sampled on posedge CLK
//  stall         in   1   decode cannot accept; IF/ID must hold its contents
//  redirect      in   1   branch/jump taken this cycle; flush and refetch
//  redirect_pc   in   32  target PC, valid when redirect=1
//  imem_req      out  1   instruction-memory request
//  imem_addr     out  32  word address of the request (= pc)
//  imem_ack      in   1   memory returns data this cycle; ignored when imem_req=0
//  imem_rdata    in   32  instruction word, valid when imem_ack=1
//  pc            out  32  current fetch PC
//  ifid_valid    out  1   IF/ID holds a live instruction
//  ifid_instr    out  32  fetched instruction
//  ifid_pc       out  32  address of ifid_instr
//  ifid_pc4      out  32  ifid_pc + 4
//  misalign_err  out  1   sticky: a redirect target had bits [1:0] != 0
// BEHAVIOUR
//  Reset (RESET=0 at posedge):
//   - state=IDLE, pc=RESET_PC, imem_req=0, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0.
//   - redirect_pend=0, hold buffer empty, misalign_err=0.
//   - Any outstanding access is abandoned; imem_ack is ignored until the next request.
//  States:
//   - IDLE: imem_req=0. Goes to REQ on the next posedge.
//   - REQ: imem_req=1. imem_addr=pc and stays stable until imem_ack.
//   - HOLD: imem_req=0. The fetched word is parked in the hold buffer.
//  Redirect target: tgt={redirect_pc[31:2],2'b00}. If redirect_pc[1:0]!=0, set misalign_err (cleared only by reset).
//  Priority within one cycle: reset > redirect > stall > normal advance.
//  REQ, redirect=1 and imem_ack=0:
//   - Latch redirect_pend=1 and pend_tgt=tgt. pc and imem_addr are unchanged.
//   - Clear ifid_valid (flush).
//  REQ, imem_ack=1 with redirect=1 or redirect_pend=1 (discard):
//   - Drop the data. pc <= tgt, or pend_tgt if no new redirect; redirect outranks pend.
//   - Clear pend and ifid_valid. Stay in REQ; the new address appears on the next cycle.
//  REQ, imem_ack=1, no discard, and (!stall or !ifid_valid):
//   - ifid <= {1, imem_rdata, pc, pc+4}; pc <= pc+4; stay in REQ.
//  REQ, imem_ack=1, no discard, stall=1 and ifid_valid=1:
//   - hold <= {imem_rdata, pc}; pc unchanged; go to HOLD.
//  HOLD:
//   - redirect: drop hold, pc <= tgt, ifid_valid <= 0, go to REQ.
//   - !stall: ifid <= {1, hold}, pc <= pc+4, go to REQ.
//   - otherwise stay in HOLD.
//  IF/ID outside the cases above:
//   - stall=1 keeps it unchanged.
//   - stall=0 with no new word: ifid_valid <= 0 and ifid_instr <= NOP_INSTR.
//  Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0. Instructions are never dropped or duplicated.
//  Throughput and latency:
//   - With imem_ack tied high, the stage delivers 1 instruction per cycle.
//   - The first valid IF/ID appears 2 posedges after reset release.
// TESTING
//  1. Reset, then imem_ack=1 constant, imem_rdata=addr-tagged -> ifid_pc 0,4,8,... one per cycle; ifid_pc4=ifid_pc+4.
//  2. stall=1 for 3 cycles mid-stream -> IF/ID frozen, HOLD entered, imem_req=0.
//     Release -> held word emitted next, no gaps or duplicates.
//  3. ack delayed 3 cycles; redirect to 0x100 in the 1st wait cycle -> imem_addr stable until ack.
//     Data discarded, next imem_addr=0x100, ifid_valid=0 meanwhile.
//  4. redirect_pc=0x203 -> misalign_err=1 (sticky), fetch resumes at 0x200.
//  5. Redirect to 0xFFFF_FFFC with ack high -> next PC is 0x0000_0000.
//  6. RESET=0 during an outstanding REQ, with ack arriving in the same cycle.
//     -> All outputs at reset values next cycle; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_stage
// Function : MIPS instruction fetch: PC/next-PC, imem req/ack port, IF/ID
//            register with a one-entry stall hold buffer and redirect handling.
// Revision : 1.0
// ============================================================================
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic        misalign_q, misalign_d;

  logic [31:0] tgt;
  logic [31:0] pc_plus4;

  assign tgt      = {redirect_pc[31:2], 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    ifpc_d       = ifpc_q;
    ifpc4_d      = ifpc4_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    misalign_d   = misalign_q | (redirect && (redirect_pc[1:0] != 2'b00));

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = tgt;
        if (redirect || !stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect || pend_q) begin
            // Word belongs to the wrong path; refetch from the newest target.
            pc_d    = redirect ? tgt : pend_tgt_q;
            pend_d  = 1'b0;
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else if (!stall || !valid_q) begin
            valid_d = 1'b1;
            instr_d = imem_rdata;
            ifpc_d  = pc_q;
            ifpc4_d = pc_plus4;
            pc_d    = pc_plus4;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end else if (redirect) begin
          // Address must stay stable until ack, so the target is remembered.
          pend_d     = 1'b1;
          pend_tgt_d = tgt;
          valid_d    = 1'b0;
          instr_d    = NOP_INSTR;
        end else if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = tgt;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = S_REQ;
        end else if (!stall) begin
          valid_d = 1'b1;
          instr_d = hold_instr_q;
          ifpc_d  = hold_pc_q;
          ifpc4_d = hold_pc_q + 32'd4;
          pc_d    = pc_plus4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= S_IDLE;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      ifpc_q       <= 32'h0;
      ifpc4_q      <= 32'h0;
      pend_q       <= 1'b0;
      pend_tgt_q   <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc_q    <= 32'h0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      ifpc_q       <= ifpc_d;
      ifpc4_q      <= ifpc4_d;
      pend_q       <= pend_d;
      pend_tgt_q   <= pend_tgt_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign ifid_valid   = valid_q;
  assign ifid_instr   = instr_q;
  assign ifid_pc      = ifpc_q;
  assign ifid_pc4     = ifpc4_q;
  assign misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_stage
// Function : Self-checking bench for if_fetch_stage (vector table + in-order
//            instruction scoreboard consumed whenever decode accepts IF/ID).
// Revision : 1.0
// ============================================================================
module tb_if_fetch_stage;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] sb[$];

  typedef struct {
    logic        stall;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_ifpc;
  } vec_t;

  vec_t tbl[11];

  always #5 CLK = ~CLK;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0000)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc     (ifid_pc),
    .ifid_pc4    (ifid_pc4),
    .misalign_err(misalign_err)
  );

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: every word is tagged with its own address.
  assign imem_rdata = tag(imem_addr);

  function automatic vec_t mk(input logic s, input logic a, input logic r,
                              input logic [31:0] ad, input logic v,
                              input logic [31:0] ip);
    vec_t t;
    t.stall = s; t.ack = a; t.exp_req = r;
    t.exp_addr = ad; t.exp_valid = v; t.exp_ifpc = ip;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic r, input logic [31:0] ad, input logic v);
    chk({nm, ".req"},   {31'h0, imem_req},   {31'h0, r});
    chk({nm, ".addr"},  imem_addr,           ad);
    chk({nm, ".valid"}, {31'h0, ifid_valid}, {31'h0, v});
  endtask

  // Decode takes IF/ID at an edge where it is valid and stall is low.
  task automatic tick();
    logic [31:0] e;
    if (RESET && !stall && ifid_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_extra: got instr at pc %h expected none", ifid_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc",    ifid_pc,    e);
        chk("sb_instr", ifid_instr, tag(e));
        chk("sb_pc4",   ifid_pc4,   e + 32'd4);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".req"},      {31'h0, imem_req},     32'h0);
    chk({nm, ".pc"},       pc,                    32'h0);
    chk({nm, ".valid"},    {31'h0, ifid_valid},   32'h0);
    chk({nm, ".instr"},    ifid_instr,            32'h0);
    chk({nm, ".ifid_pc"},  ifid_pc,               32'h0);
    chk({nm, ".ifid_pc4"}, ifid_pc4,              32'h0);
    chk({nm, ".misalign"}, {31'h0, misalign_err}, 32'h0);
  endtask

  initial begin
    RESET = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_pc = 32'h0; imem_ack = 1'b0;
    tick();
    tick();
    chk_reset("reset");

    // Streaming with ack high, then a 3-cycle stall, then an ack bubble.
    tbl[0]  = mk(1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
    tbl[1]  = mk(1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00);
    tbl[2]  = mk(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04);
    tbl[3]  = mk(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08);
    tbl[4]  = mk(1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h08);
    tbl[5]  = mk(1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h08);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 32'h0C, 1'b1, 32'h08);
    tbl[7]  = mk(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C);
    tbl[8]  = mk(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10);
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 32'h14, 1'b0, 32'h00);
    tbl[10] = mk(1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h14);
    for (int a = 0; a <= 20; a += 4) sb.push_back(32'(a));

    RESET = 1'b1;
    for (int i = 0; i < 11; i++) begin
      stall = tbl[i].stall;
      imem_ack = tbl[i].ack;
      tick();
      chk_out($sformatf("vec%0d", i), tbl[i].exp_req, tbl[i].exp_addr, tbl[i].exp_valid);
      if (tbl[i].exp_valid)
        chk($sformatf("vec%0d.ifid_pc", i), ifid_pc, tbl[i].exp_ifpc);
    end
    stall = 1'b0;

    // Redirect during a 3-cycle ack wait: address stable, data discarded.
    imem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    chk_out("redir_wait0", 1'b1, 32'h18, 1'b0);
    redirect = 1'b0;
    tick();
    chk_out("redir_wait1", 1'b1, 32'h18, 1'b0);
    tick();
    chk_out("redir_wait2", 1'b1, 32'h18, 1'b0);
    imem_ack = 1'b1;
    tick();
    chk_out("redir_discard", 1'b1, 32'h100, 1'b0);
    sb.push_back(32'h100);
    sb.push_back(32'h104);
    tick();
    chk_out("redir_first", 1'b1, 32'h104, 1'b1);
    tick();
    chk("misalign_clear", {31'h0, misalign_err}, 32'h0);

    // Misaligned target: sticky error, fetch realigned to 0x200.
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    chk_out("misal_redir", 1'b1, 32'h200, 1'b0);
    chk("misalign_set", {31'h0, misalign_err}, 32'h1);
    redirect = 1'b0;
    sb.push_back(32'h200);
    sb.push_back(32'h204);
    tick();
    chk_out("misal_first", 1'b1, 32'h204, 1'b1);
    tick();
    chk("misalign_sticky", {31'h0, misalign_err}, 32'h1);

    // Redirect to the top word: PC wraps to zero.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    chk_out("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b0);
    redirect = 1'b0;
    sb.push_back(32'hFFFF_FFFC);
    tick();
    chk_out("wrap_next", 1'b1, 32'h0, 1'b1);
    tick();

    // Reset while a request is outstanding and acked in the same cycle.
    RESET = 1'b0; imem_ack = 1'b1;
    tick();
    chk_reset("reset_mid");
    RESET = 1'b1;
    tick();
    chk_out("restart0", 1'b1, 32'h0, 1'b0);
    sb.push_back(32'h0);
    tick();
    chk_out("restart1", 1'b1, 32'h4, 1'b1);
    imem_ack = 1'b0;
    tick();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
